// File: rtl/clean_session_ctrl.sv
// -----------------------------------------------------------------------------
// clean_session_ctrl
//
// Initiator side of the hood self-clean interface. A debounced clean request
// is checked against the power/idle preconditions, then clean_mode_sel is
// raised towards the self-clean countdown block. The returned countdown and
// done flag are supervised:
//   - mode_sel is dropped on the same edge that samples clean_timer==1, so the
//     countdown block finishes without reloading;
//   - the done flag must follow on the next sample, otherwise FAULT;
//   - a stuck responder (timer stays 0 in START) or an overlong session
//     (watchdog over START+RUN) also ends in FAULT.
// Successful completion pulses done_pulse and sounds the buzzer until it is
// acknowledged or ALERT_CYCLES have elapsed.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   clean_btn      in   1-cycle pulse, user requests self-clean
//   cancel_btn     in   1-cycle pulse, user aborts session
//   ack_btn        in   1-cycle pulse, silences buzzer / clears fault
//   power_on       in   hood powered
//   hood_idle      in   fan and light off
//   clean_timer    in   countdown from the self-clean block (seconds)
//   clean_done     in   completion flag from the self-clean block
//   clean_mode_sel out  mode select to the self-clean block
//   remaining      out  clean_timer (one cycle late) in START/RUN, else 0
//   busy           out  high in START, RUN, FINISH
//   buzzer         out  completion alert
//   fault          out  high in FAULT
//   done_pulse     out  1-cycle pulse on successful completion
//   reject_pulse   out  1-cycle pulse when clean_btn is refused
// All outputs are registered.
// -----------------------------------------------------------------------------
module clean_session_ctrl #(
  parameter int WATCHDOG_CYCLES = 200,
  parameter int START_LIMIT     = 4,
  parameter int ALERT_CYCLES    = 5,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clean_btn,
  input  logic              cancel_btn,
  input  logic              ack_btn,
  input  logic              power_on,
  input  logic              hood_idle,
  input  logic [DATA_W-1:0] clean_timer,
  input  logic              clean_done,
  output logic              clean_mode_sel,
  output logic [DATA_W-1:0] remaining,
  output logic              busy,
  output logic              buzzer,
  output logic              fault,
  output logic              done_pulse,
  output logic              reject_pulse
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam int SL_W = $clog2(START_LIMIT + 1);
  localparam int AL_W = $clog2(ALERT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_FINISH = 3'd3,
    S_ALERT  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WD_W-1:0] wd_cnt;
  logic [SL_W-1:0] start_cnt;
  logic [AL_W-1:0] alert_cnt;

  logic abort;
  logic wd_expired;
  logic start_expired;
  logic alert_expired;
  logic active_now;
  logic active_nxt;

  logic              mode_sel_d;
  logic [DATA_W-1:0] remaining_d;
  logic              busy_d;
  logic              buzzer_d;
  logic              fault_d;
  logic              done_pulse_d;
  logic              reject_pulse_d;

  // Each counter holds the number of completed cycles already spent, so the
  // limit fires on the sample that would complete the N-th cycle.
  assign abort         = cancel_btn | ~power_on;
  assign wd_expired    = (wd_cnt    >= WD_W'(WATCHDOG_CYCLES - 1));
  assign start_expired = (start_cnt >= SL_W'(START_LIMIT - 1));
  assign alert_expired = (alert_cnt >= AL_W'(ALERT_CYCLES - 1));
  assign active_now    = (state == S_START) || (state == S_RUN);
  assign active_nxt    = (state_nxt == S_START) || (state_nxt == S_RUN);

  // Next-state logic. In START/RUN the order is abort, watchdog, then the
  // normal handshake, so cancel beats clean_timer==1 in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (clean_btn && power_on && hood_idle) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (wd_expired) begin
          state_nxt = S_FAULT;
        end else if (clean_timer != '0) begin
          state_nxt = S_RUN;
        end else if (start_expired) begin
          state_nxt = S_FAULT;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (wd_expired) begin
          state_nxt = S_FAULT;
        end else if (clean_timer == DATA_W'(1)) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        state_nxt = clean_done ? S_ALERT : S_FAULT;
      end
      S_ALERT: begin
        if (ack_btn || alert_expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (ack_btn) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the registered outputs describe the state being entered,
  // which makes mode_sel drop on the very edge that sees clean_timer==1.
  always_comb begin
    mode_sel_d     = active_nxt;
    remaining_d    = active_nxt ? clean_timer : '0;
    busy_d         = active_nxt || (state_nxt == S_FINISH);
    buzzer_d       = (state_nxt == S_ALERT);
    fault_d        = (state_nxt == S_FAULT);
    done_pulse_d   = (state == S_FINISH) && (state_nxt == S_ALERT);
    reject_pulse_d = (state == S_IDLE) && clean_btn && (state_nxt == S_IDLE);
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      wd_cnt         <= '0;
      start_cnt      <= '0;
      alert_cnt      <= '0;
      clean_mode_sel <= 1'b0;
      remaining      <= '0;
      busy           <= 1'b0;
      buzzer         <= 1'b0;
      fault          <= 1'b0;
      done_pulse     <= 1'b0;
      reject_pulse   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Watchdog spans START and RUN; any entry into START comes from
      // outside that pair, so it always starts from zero.
      if (active_now && active_nxt) begin
        if (wd_cnt < WD_W'(WATCHDOG_CYCLES)) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end

      if ((state == S_START) && (state_nxt == S_START)) begin
        if (start_cnt < SL_W'(START_LIMIT)) begin
          start_cnt <= start_cnt + 1'b1;
        end
      end else begin
        start_cnt <= '0;
      end

      if ((state == S_ALERT) && (state_nxt == S_ALERT)) begin
        if (alert_cnt < AL_W'(ALERT_CYCLES)) begin
          alert_cnt <= alert_cnt + 1'b1;
        end
      end else begin
        alert_cnt <= '0;
      end

      clean_mode_sel <= mode_sel_d;
      remaining      <= remaining_d;
      busy           <= busy_d;
      buzzer         <= buzzer_d;
      fault          <= fault_d;
      done_pulse     <= done_pulse_d;
      reject_pulse   <= reject_pulse_d;
    end
  end

endmodule
